pc_gen: RTL

Parametrised program-counter generator for the IF stage of the RISC-V pipeline, replacing the plain PC register. It holds the fetch PC and drives the instruction-memory handshake. It selects the next PC by fixed priority: trap, resolved branch/jump redirect, optional return-address prediction, then sequential. It also flags misaligned redirect targets.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the program-counter generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Fetch-side control state: BOOT is the single post-reset bubble
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  // Next-PC source, listed in priority order
  typedef enum logic [2:0] {
    SRC_TRAP = 3'd0,
    SRC_BR   = 3'd1,
    SRC_RAS  = 3'd2,
    SRC_SEQ  = 3'd3,
    SRC_HOLD = 3'd4
  } pc_src_e;

  // Low PC bits that must be zero for a 4-byte aligned fetch address
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. Push on call, pop on return,
//               simultaneous push+pop replaces the top entry. Pushing when
//               full overwrites the oldest entry. Flush empties the stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  r_stack [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_replace;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_top     = r_stack[r_ptr];
  // Call and return together on a non-empty stack rewrite the current top
  assign w_replace = i_push & i_pop & ~o_empty;
  assign w_wr_en   = ~i_flush & i_push;
  assign w_wr_idx  = w_replace ? r_ptr : r_ptr + PTR_W'(1);

  // Pointer and occupancy; the pointer wraps so a full push drops the oldest
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (w_replace) begin
      r_count <= r_count;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!w_full) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage has no reset; the occupancy count guards stale data
  always_ff @(negedge clk) begin
    if (w_wr_en) begin
      r_stack[w_wr_idx] <= i_data;
    end
  end

endmodule : pc_ras
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : IF-stage program-counter generator. Next PC by priority:
//               trap, branch redirect, return-address prediction, sequential.
//               All state updates on the falling clock edge.
//               Optional feature macro: PC_RAS_EN (return-address stack).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            if_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misalign,
  output logic            ras_pred
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(ALIGN_MASK);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_misalign;
  logic            r_ras_pred;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_hit;
  logic            w_adv;
  pc_src_e         w_src;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_adv      = r_pc_valid & if_ready & ~stall;

`ifdef PC_RAS_EN
  logic w_ras_empty;
  logic w_redirect;

  // A redirect squashes the instruction in IF, so its call/return is ignored
  assign w_redirect = trap | br_taken;
  assign w_ras_hit  = w_adv & is_ret & ~w_ras_empty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_adv & is_call & ~w_redirect),
    .i_pop   (w_adv & is_ret & ~w_redirect),
    .i_flush (trap),
    .i_data  (w_pc_plus4),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );
`else
  wire w_unused = &{1'b0, is_call, is_ret, RAS_DEPTH[0]};

  assign w_ras_hit = 1'b0;
  assign w_ras_top = '0;
`endif

  // Fixed-priority next-PC source selection
  always_comb begin
    w_src = SRC_HOLD;
    if (trap) begin
      w_src = SRC_TRAP;
    end else if (br_taken) begin
      w_src = SRC_BR;
    end else if (w_ras_hit) begin
      w_src = SRC_RAS;
    end else if (w_adv) begin
      w_src = SRC_SEQ;
    end
  end

  // PC register, BOOT/RUN sequencing and registered status flags
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_ras_pred <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (w_src)
        SRC_TRAP: begin
          r_pc       <= trap_vec & ~LOW_MASK;
          r_ras_pred <= 1'b0;
        end
        SRC_BR: begin
          r_pc       <= br_target & ~LOW_MASK;
          r_misalign <= |(br_target & LOW_MASK);
          r_ras_pred <= 1'b0;
        end
        SRC_RAS: begin
          r_pc       <= w_ras_top;
          r_ras_pred <= 1'b1;
        end
        SRC_SEQ: begin
          r_pc       <= w_pc_plus4;
          r_ras_pred <= 1'b0;
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
      // BOOT lasts exactly one edge, redirect or not
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        default: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
      endcase
    end
  end

  assign pc_out   = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign pc_valid = r_pc_valid;
  assign misalign = r_misalign;
  assign ras_pred = r_ras_pred;

endmodule : pc_gen
`default_nettype wire
